spike_isi_monitor: RTL and testbench
====================================

// Module: spike_isi_monitor
// PURPOSE
//  Downstream consumer of the LIF neuron: takes its spike pulse and 8-bit membrane state,
//  produces windowed spike rate, per-window peak membrane state, and a stream of
//  inter-spike intervals (ISIs) through a small valid/ready FIFO. Sits between lif and
//  the output pins / a host readout.
// PARAMETERS
//  STATE_W     8   width of membrane state input and peak_state output
//  WIN_W       8   width of window-length input and window down-counter
//  CNT_W       8   width of per-window spike count (saturating)
//  ISI_W       8   width of ISI values (saturating)
//  FIFO_DEPTH  4   ISI FIFO entries (power of two, >=2)
// PORTS
//  clk         in   1        clock, all state on rising edge
//  reset       in   1        asynchronous, active-high reset
//  spike_in    in   1        spike from lif
//  state_in    in   STATE_W  membrane state from lif (unsigned)
//  win_len     in   WIN_W    window length in cycles; sampled at each window start
//  rate_count  out  CNT_W    spikes counted in last completed window (held)
//  rate_valid  out  1        one-cycle pulse when rate_count/peak_state update
//  peak_state  out  STATE_W  max state_in seen in last completed window (held)
//  isi_data    out  ISI_W    ISI at FIFO head
//  isi_valid   out  1        FIFO not empty
//  isi_ready   in   1        consumer accepts isi_data when isi_valid&&isi_ready
//  isi_ovf     out  1        sticky: an ISI was dropped because FIFO was full
// BEHAVIOUR
//  - Reset: every register and output 0; FIFO empty; ISI unarmed; window idle.
//  - Edge detect: spike_q <= spike_in; edge = spike_in & ~spike_q. A held-high spike counts once.
//  - Window: first cycle after reset (or after a window ends) loads win_cnt <= win_len.
//    win_len==0: window disabled, rate_valid never pulses, counters held at 0.
//    Window spans exactly win_len cycles; edges and state_in of the final cycle are included.
//    At end: rate_count <= sat(spk_cnt + edge), peak_state <= max(peak_acc, state_in),
//    rate_valid=1 next cycle only; spk_cnt/peak_acc restart from 0 for the next window.
//    spk_cnt saturates at 2^CNT_W-1, never wraps. win_len changes mid-window take effect next window.
//  - ISI counter: on edge, isi_cnt <= 1; else isi_cnt <= sat(isi_cnt+1) at 2^ISI_W-1.
//    First edge after reset only arms. Each later edge pushes current isi_cnt
//    (= cycles since previous edge, min 2) into FIFO. Pushed value visible on
//    isi_data/isi_valid the cycle after the edge (latency 1).
//  - FIFO: pop when isi_valid&&isi_ready. Push when full and no pop: value dropped,
//    isi_ovf <= 1 (sticky until reset). Push+pop same cycle when full: both happen,
//    no drop. Push+pop when empty: not possible (isi_valid=0), push occurs.
//    Pointers wrap modulo FIFO_DEPTH; count register distinguishes full/empty.
//    isi_data is registered/mux from storage, stable while isi_valid&&!isi_ready.
//  - Reset mid-operation: async clear of all state, including FIFO contents and arm flag.
// STRUCTURE
//  - Shared package/header: STATE_W, ISI_W, CNT_W defaults and the saturating-increment
//    function, reused by lif and later readout blocks.
//  - Sub-module isi_fifo (DEPTH, WIDTH; push/data_in, pop, data_out, empty, full).
//  - Top: edge detect, window FSM (IDLE_LOAD, COUNT), ISI counter, peak tracker.
// TESTING
//  1 win_len=10, spike_in pulses at cycles 2,5,9 -> rate_valid once, rate_count=3;
//    next window no spikes -> rate_count=0.
//  2 Edges at cycles 10 and 17, isi_ready=1 -> isi_data=7, isi_valid high one cycle (18);
//    first edge alone -> nothing pushed.
//  3 isi_ready=0, 6 spaced spikes (5 ISIs) -> FIFO holds first 4 in order, isi_ovf=1;
//    then isi_ready=1 drains exactly 4 values, isi_ovf stays 1.
//  4 Spike held high 8 cycles -> counted once; no spikes for 300 cycles then edge ->
//    isi_data=255 (saturated).
//  5 FIFO full, isi_ready=1 and edge same cycle -> no drop, isi_ovf stays 0, order kept.
//  6 state_in ramp 0..200 in window of 20 with max 200 on last cycle -> peak_state=200;
//    assert reset mid-window -> all outputs 0 immediately, win_len=0 -> no rate_valid.

Source files
------------

// File: rtl/spike_isi_monitor_pkg.sv
// Shared widths, window FSM encoding and saturating increment for the spike
// processing chain (lif, spike_isi_monitor, readout).
package spike_isi_monitor_pkg;

  localparam int DEF_STATE_W    = 8;
  localparam int DEF_WIN_W      = 8;
  localparam int DEF_CNT_W      = 8;
  localparam int DEF_ISI_W      = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic {
    WIN_IDLE_LOAD = 1'b0,
    WIN_COUNT     = 1'b1
  } win_state_t;

  // Increment v by one when inc is set, sticking at max_v instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                          input logic [31:0] max_v,
                                          input logic        inc);
    return (inc && (v < max_v)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/spike_isi_monitor_isi_fifo.sv
// Small synchronous FIFO for ISI values; head is read straight from storage so
// data_out stays stable until the entry is popped.
module isi_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so push into a full FIFO is legal then.
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign data_out = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/spike_isi_monitor.sv
// Windowed spike rate / peak membrane state and an inter-spike-interval stream
// for the lif neuron output.
module spike_isi_monitor
  import spike_isi_monitor_pkg::*;
#(
  parameter int STATE_W    = DEF_STATE_W,
  parameter int WIN_W      = DEF_WIN_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int ISI_W      = DEF_ISI_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               spike_in,
  input  logic [STATE_W-1:0] state_in,
  input  logic [WIN_W-1:0]   win_len,
  output logic [CNT_W-1:0]   rate_count,
  output logic               rate_valid,
  output logic [STATE_W-1:0] peak_state,
  // isi stream: a value transfers on a cycle with isi_valid && isi_ready;
  // isi_data holds steady while isi_valid && !isi_ready.
  output logic [ISI_W-1:0]   isi_data,
  output logic               isi_valid,
  input  logic               isi_ready,
  output logic               isi_ovf,
  output win_state_t         dbg_win_state
);

  localparam logic [31:0] CNT_MAX = 32'((2 ** CNT_W) - 1);
  localparam logic [31:0] ISI_MAX = 32'((2 ** ISI_W) - 1);

  logic               spike_q;
  logic               spk_edge;
  win_state_t         win_state;
  logic [WIN_W-1:0]   win_cnt;
  logic [CNT_W-1:0]   spk_cnt;
  logic [CNT_W-1:0]   spk_next;
  logic [STATE_W-1:0] peak_acc;
  logic [STATE_W-1:0] peak_next;
  logic [ISI_W-1:0]   isi_cnt;
  logic               armed;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_empty;
  logic               fifo_full;

  assign spk_edge      = spike_in & ~spike_q;
  assign spk_next      = CNT_W'(sat_inc(32'(spk_cnt), CNT_MAX, spk_edge));
  assign peak_next     = (state_in > peak_acc) ? state_in : peak_acc;
  assign dbg_win_state = win_state;

  // The load cycle only captures win_len; the following win_len cycles are counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spike_q    <= 1'b0;
      win_state  <= WIN_IDLE_LOAD;
      win_cnt    <= '0;
      spk_cnt    <= '0;
      peak_acc   <= '0;
      rate_count <= '0;
      peak_state <= '0;
      rate_valid <= 1'b0;
    end else begin
      spike_q    <= spike_in;
      rate_valid <= 1'b0;
      case (win_state)
        WIN_IDLE_LOAD: begin
          win_cnt  <= win_len;
          spk_cnt  <= '0;
          peak_acc <= '0;
          if (win_len != '0) win_state <= WIN_COUNT;
        end
        WIN_COUNT: begin
          if (win_cnt == WIN_W'(1)) begin
            rate_count <= spk_next;
            peak_state <= peak_next;
            rate_valid <= 1'b1;
            spk_cnt    <= '0;
            peak_acc   <= '0;
            win_cnt    <= '0;
            win_state  <= WIN_IDLE_LOAD;
          end else begin
            win_cnt  <= win_cnt - 1'b1;
            spk_cnt  <= spk_next;
            peak_acc <= peak_next;
          end
        end
        default: win_state <= WIN_IDLE_LOAD;
      endcase
    end
  end

  assign fifo_push = spk_edge & armed;
  assign fifo_pop  = isi_valid & isi_ready;
  assign isi_valid = ~fifo_empty;

  // The first edge after reset has no predecessor, so it only arms the interval timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      isi_cnt <= '0;
      armed   <= 1'b0;
      isi_ovf <= 1'b0;
    end else begin
      if (spk_edge) begin
        isi_cnt <= ISI_W'(1);
        armed   <= 1'b1;
      end else begin
        isi_cnt <= ISI_W'(sat_inc(32'(isi_cnt), ISI_MAX, 1'b1));
      end
      if (fifo_push && fifo_full && !fifo_pop) isi_ovf <= 1'b1;
    end
  end

  isi_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ISI_W)
  ) u_isi_fifo (
    .clk      (clk),
    .rst      (reset),
    .push     (fifo_push),
    .data_in  (isi_cnt),
    .pop      (fifo_pop),
    .data_out (isi_data),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

endmodule

// File: tb/tb_spike_isi_monitor.sv
// Directed scenarios plus random traffic for spike_isi_monitor, checked every
// cycle against a cycle-count / queue reference model.
module tb_spike_isi_monitor;
  import spike_isi_monitor_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       spike_in;
  logic [7:0] state_in;
  logic [7:0] win_len;
  logic       isi_ready;
  logic [7:0] rate_count;
  logic       rate_valid;
  logic [7:0] peak_state;
  logic [7:0] isi_data;
  logic       isi_valid;
  logic       isi_ovf;
  win_state_t dbg_win_state;

  always #5 clk = ~clk;

  spike_isi_monitor dut (
    .clk           (clk),
    .reset         (reset),
    .spike_in      (spike_in),
    .state_in      (state_in),
    .win_len       (win_len),
    .rate_count    (rate_count),
    .rate_valid    (rate_valid),
    .peak_state    (peak_state),
    .isi_data      (isi_data),
    .isi_valid     (isi_valid),
    .isi_ready     (isi_ready),
    .isi_ovf       (isi_ovf),
    .dbg_win_state (dbg_win_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int         cyc;
  logic       m_prev;
  bit         m_armed;
  int         m_last_edge;
  bit         m_ovf;
  logic [7:0] exp_q[$];
  bit         m_in_window;
  int         m_len, m_pos, m_spikes, m_peak;
  logic       e_rate_valid;
  logic [7:0] e_rate_count, e_peak;

  task automatic model_reset();
    m_prev = 1'b0; m_armed = 0; m_last_edge = 0; m_ovf = 0;
    exp_q.delete();
    m_in_window = 0; m_len = 0; m_pos = 0; m_spikes = 0; m_peak = 0;
    e_rate_valid = 1'b0; e_rate_count = 8'd0; e_peak = 8'd0;
  endtask

  // Applies this cycle's inputs; afterwards the e_* values and exp_q describe
  // what the DUT must show just after the coming rising edge.
  task automatic model_eval();
    bit edge_now;
    int isi;
    edge_now = spike_in && !m_prev;
    m_prev   = spike_in;
    e_rate_valid = 1'b0;
    if (!m_in_window) begin
      m_len = int'(win_len); m_pos = 0; m_spikes = 0; m_peak = 0;
      m_in_window = (win_len != 0);
    end else begin
      m_pos++;
      if (edge_now) m_spikes++;
      if (int'(state_in) > m_peak) m_peak = int'(state_in);
      if (m_pos == m_len) begin
        e_rate_valid = 1'b1;
        e_rate_count = 8'((m_spikes > 255) ? 255 : m_spikes);
        e_peak       = 8'(m_peak);
        m_in_window  = 0;
      end
    end
    if (exp_q.size() > 0 && isi_ready) void'(exp_q.pop_front());
    if (edge_now) begin
      if (m_armed) begin
        isi = cyc - m_last_edge;
        if (isi > 255) isi = 255;
        if (exp_q.size() < 4) exp_q.push_back(8'(isi));
        else m_ovf = 1;
      end
      m_armed = 1; m_last_edge = cyc;
    end
    cyc++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic check_outputs();
    chk("rate_valid", 32'(rate_valid), 32'(e_rate_valid));
    chk("rate_count", 32'(rate_count), 32'(e_rate_count));
    chk("peak_state", 32'(peak_state), 32'(e_peak));
    chk("isi_valid", 32'(isi_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) chk("isi_data", 32'(isi_data), 32'(exp_q[0]));
    chk("isi_ovf", 32'(isi_ovf), 32'(m_ovf));
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic tick();
    model_eval();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Reset is raised mid-cycle so the clear must come from the async path.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_rate_count", 32'(rate_count), 32'd0);
    chk("rst_rate_valid", 32'(rate_valid), 32'd0);
    chk("rst_peak_state", 32'(peak_state), 32'd0);
    chk("rst_isi_valid", 32'(isi_valid), 32'd0);
    chk("rst_isi_ovf", 32'(isi_ovf), 32'd0);
    chk("rst_win_state", 32'(dbg_win_state), 32'(WIN_IDLE_LOAD));
    model_reset();
    @(negedge clk);
    @(negedge clk);
    spike_in = 1'b0;
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; spike_in = 1'b0; state_in = 8'd0; win_len = 8'd0; isi_ready = 1'b0;
    cyc = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // rate over a 10-cycle window, then an empty window
    win_len = 8'd10; isi_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      spike_in = (c == 2 || c == 5 || c == 9);
      tick();
    end

    // single ISI of 7 cycles; the arming edge pushes nothing
    do_reset();
    win_len = 8'd0; isi_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      spike_in = (c == 10 || c == 17);
      tick();
      if (c == 17) chk("isi_seven", 32'(isi_data), 32'd7);
    end

    // overflow: five ISIs into four slots, then drain
    do_reset();
    isi_ready = 1'b0;
    for (int c = 0; c < 36; c++) begin
      spike_in = (c % 6 == 0) && (c < 31);
      tick();
    end
    spike_in = 1'b0; isi_ready = 1'b1;
    run(8);
    chk("ovf_sticky", 32'(isi_ovf), 32'd1);

    // held spike counts once, long silence saturates the ISI
    do_reset();
    win_len = 8'd12; isi_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      spike_in = (c >= 3 && c < 11);
      tick();
    end
    spike_in = 1'b0;
    run(300);
    spike_in = 1'b1; tick();
    chk("isi_sat", 32'(isi_data), 32'd255);
    spike_in = 1'b0;
    run(4);

    // full FIFO with pop and push in the same cycle
    do_reset();
    win_len = 8'd0; isi_ready = 1'b0;
    for (int c = 0; c < 21; c++) begin
      spike_in  = (c % 4 == 0);
      isi_ready = (c == 20);
      tick();
    end
    spike_in = 1'b0; isi_ready = 1'b1;
    run(8);
    chk("no_drop_ovf", 32'(isi_ovf), 32'd0);

    // ramp with peak on the final window cycle, then reset mid-window
    do_reset();
    win_len = 8'd20; isi_ready = 1'b1;
    for (int c = 0; c < 21; c++) begin
      state_in = 8'(c * 10);
      tick();
    end
    chk("peak_ramp", 32'(peak_state), 32'd200);
    state_in = 8'd30;
    run(7);
    do_reset();
    win_len = 8'd0;
    for (int c = 0; c < 40; c++) begin
      spike_in = ($urandom_range(0, 2) == 0);
      state_in = 8'($urandom_range(0, 255));
      tick();
    end

    // random traffic
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      if (c % 150 == 0) win_len = 8'($urandom_range(0, 12));
      spike_in  = ($urandom_range(0, 3) == 0);
      state_in  = 8'($urandom_range(0, 255));
      isi_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
